// File: rtl/simon_req_sched.sv
`default_nettype none
// ============================================================================
// Module      : simon_req_sched
// Description : Credit-based round-robin admission scheduler in front of a
//               fully unrolled simon32_64 core. It tracks the source and tag
//               of every block through the fixed core latency and queues the
//               completed ciphertexts behind a valid/ready response port.
//               Optional statistics counters: define SIMON_SCHED_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module simon_req_sched #(
    parameter int NREQ     = 2,
    parameter int LAT      = 34,
    parameter int OQ_DEPTH = 4,
    parameter int ID_W     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*32-1:0]        req_pt,
    input  logic [NREQ*64-1:0]        req_key,
    input  logic [NREQ*ID_W-1:0]      req_id,
    output logic [NREQ-1:0]           req_ready,
    output logic [31:0]               core_pt,
    output logic [63:0]               core_key,
    input  logic [31:0]               core_ct,
    output logic                      rsp_valid,
    output logic [31:0]               rsp_data,
    output logic [$clog2(NREQ)-1:0]   rsp_src,
    output logic [ID_W-1:0]           rsp_id,
    input  logic                      rsp_ready,
    input  logic                      flush,
    output logic                      idle
`ifdef SIMON_SCHED_STATS_EN
    ,
    output logic [NREQ*16-1:0]        stat_grants,
    output logic [15:0]               stat_stall
`endif
);

    localparam int c_SRC_W = $clog2(NREQ);
    localparam int c_CNT_W = $clog2(OQ_DEPTH + 1);
    localparam int c_PTR_W = $clog2(OQ_DEPTH);

    localparam logic [0:0] c_ST_RUN   = 1'b0;
    localparam logic [0:0] c_ST_DRAIN = 1'b1;

    logic [0:0]         r_state;
    logic [c_SRC_W-1:0] r_rr;
    logic [c_CNT_W-1:0] r_inflight;
    logic [c_CNT_W-1:0] r_oq_cnt;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [31:0]        r_oq_data [OQ_DEPTH];
    logic [c_SRC_W-1:0] r_oq_src  [OQ_DEPTH];
    logic [ID_W-1:0]    r_oq_id   [OQ_DEPTH];
    logic               r_tag_v   [LAT];
    logic [c_SRC_W-1:0] r_tag_src [LAT];
    logic [ID_W-1:0]    r_tag_id  [LAT];

    logic [c_CNT_W:0]   w_load;
    logic               w_credit;
    logic               w_admit;
    logic               w_sel_any;
    logic [c_SRC_W-1:0] w_sel_idx;
    logic               w_grant_any;
    logic [c_SRC_W-1:0] w_grant_idx;
    logic [ID_W-1:0]    w_grant_id;
    logic               w_push;
    logic               w_pop;
    logic [c_PTR_W-1:0] w_wr_ptr_nxt;
    logic [c_PTR_W-1:0] w_rd_ptr_nxt;

    // Credits cover both blocks inside the core and results already queued,
    // so every block that leaves the core is guaranteed a queue slot.
    assign w_load   = {1'b0, r_inflight} + {1'b0, r_oq_cnt};
    assign w_credit = w_load < (c_CNT_W + 1)'(OQ_DEPTH);
    // Reset gates admission directly so req_ready drops the moment reset asserts
    assign w_admit  = reset && (r_state == c_ST_RUN) && w_credit;

    // Round-robin search: first valid requester at or after r_rr
    always_comb begin
        logic [c_SRC_W:0]   v_sum;
        logic [c_SRC_W-1:0] v_idx;
        w_sel_any = 1'b0;
        w_sel_idx = '0;
        v_sum     = '0;
        v_idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            v_sum = {1'b0, r_rr} + (c_SRC_W + 1)'(k);
            if (v_sum >= (c_SRC_W + 1)'(NREQ)) begin
                v_sum = v_sum - (c_SRC_W + 1)'(NREQ);
            end
            v_idx = v_sum[c_SRC_W-1:0];
            if (!w_sel_any && req_valid[v_idx]) begin
                w_sel_any = 1'b1;
                w_sel_idx = v_idx;
            end
        end
    end

    assign w_grant_any = w_sel_any && w_admit;
    assign w_grant_idx = w_sel_idx;
    assign w_grant_id  = w_grant_any ? req_id[ID_W*w_grant_idx +: ID_W] : '0;

    // One-hot grant and zero-when-idle core input muxes
    always_comb begin
        req_ready = '0;
        core_pt   = '0;
        core_key  = '0;
        if (w_grant_any) begin
            req_ready[w_grant_idx] = 1'b1;
            core_pt                = req_pt[32*w_grant_idx +: 32];
            core_key               = req_key[64*w_grant_idx +: 64];
        end
    end

    assign w_push       = r_tag_v[LAT-1];
    assign w_pop        = rsp_valid && rsp_ready;
    assign w_wr_ptr_nxt = (r_wr_ptr == c_PTR_W'(OQ_DEPTH - 1)) ? '0 : r_wr_ptr + c_PTR_W'(1);
    assign w_rd_ptr_nxt = (r_rd_ptr == c_PTR_W'(OQ_DEPTH - 1)) ? '0 : r_rd_ptr + c_PTR_W'(1);

    // Tag pipe: {valid, source, id} shadows each block through the core
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LAT; i++) begin
                r_tag_v[i]   <= 1'b0;
                r_tag_src[i] <= '0;
                r_tag_id[i]  <= '0;
            end
        end else begin
            r_tag_v[0]   <= w_grant_any;
            r_tag_src[0] <= w_grant_idx;
            r_tag_id[0]  <= w_grant_id;
            for (int i = 1; i < LAT; i++) begin
                r_tag_v[i]   <= r_tag_v[i-1];
                r_tag_src[i] <= r_tag_src[i-1];
                r_tag_id[i]  <= r_tag_id[i-1];
            end
        end
    end

    // Output queue: circular buffer written by tag exits, read by the consumer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_oq_cnt <= '0;
            for (int i = 0; i < OQ_DEPTH; i++) begin
                r_oq_data[i] <= '0;
                r_oq_src[i]  <= '0;
                r_oq_id[i]   <= '0;
            end
        end else begin
            if (w_push) begin
                r_oq_data[r_wr_ptr] <= core_ct;
                r_oq_src[r_wr_ptr]  <= r_tag_src[LAT-1];
                r_oq_id[r_wr_ptr]   <= r_tag_id[LAT-1];
                r_wr_ptr            <= w_wr_ptr_nxt;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_push, w_pop})
                2'b10:   r_oq_cnt <= r_oq_cnt + c_CNT_W'(1);
                2'b01:   r_oq_cnt <= r_oq_cnt - c_CNT_W'(1);
                default: r_oq_cnt <= r_oq_cnt;
            endcase
        end
    end

    // In-flight count, round-robin pointer and RUN/DRAIN state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_inflight <= '0;
            r_rr       <= '0;
            r_state    <= c_ST_RUN;
        end else begin
            case ({w_grant_any, w_push})
                2'b10:   r_inflight <= r_inflight + c_CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - c_CNT_W'(1);
                default: r_inflight <= r_inflight;
            endcase
            if (w_grant_any) begin
                r_rr <= (w_grant_idx == c_SRC_W'(NREQ - 1)) ? '0 : w_grant_idx + c_SRC_W'(1);
            end
            case (r_state)
                c_ST_RUN: begin
                    if (flush) r_state <= c_ST_DRAIN;
                end
                c_ST_DRAIN: begin
                    // Resume only once fully empty, even if flush drops early
                    if (!flush && r_inflight == '0 && r_oq_cnt == '0) r_state <= c_ST_RUN;
                end
                default: r_state <= c_ST_RUN;
            endcase
        end
    end

    assign rsp_valid = (r_oq_cnt != '0);
    assign rsp_data  = r_oq_data[r_rd_ptr];
    assign rsp_src   = r_oq_src[r_rd_ptr];
    assign rsp_id    = r_oq_id[r_rd_ptr];
    assign idle      = (r_state == c_ST_DRAIN) && (r_inflight == '0) && (r_oq_cnt == '0);

`ifdef SIMON_SCHED_STATS_EN
    logic [15:0] r_stat_grants [NREQ];
    logic [15:0] r_stat_stall;

    // Saturating per-requester grant counters and stalled-request cycle counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREQ; i++) begin
                r_stat_grants[i] <= '0;
            end
            r_stat_stall <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i] && r_stat_grants[i] != 16'hFFFF) begin
                    r_stat_grants[i] <= r_stat_grants[i] + 16'd1;
                end
            end
            if ((|req_valid) && !w_grant_any && r_stat_stall != 16'hFFFF) begin
                r_stat_stall <= r_stat_stall + 16'd1;
            end
        end
    end

    generate
        for (genvar g = 0; g < NREQ; g++) begin : g_stat_out
            assign stat_grants[16*g +: 16] = r_stat_grants[g];
        end
    endgenerate

    assign stat_stall = r_stat_stall;
`endif

endmodule
`default_nettype wire
